uart_rx_sync: RTL and testbench
===============================

Name: uart_rx_sync

Overview:
- Hardened UART receiver; sits directly upstream of the command/mux control block and feeds it one byte per rx_ready pulse.
- Frame format: 8N1, LSB first, idle high.
- Adds a 2-flop input synchroniser, mid-bit 3-sample majority voting, false-start rejection, stop-bit checking and framing-error reporting.
- Output contract is a fully synchronous single-cycle pulse, so consumers clock on clk only.

Parameters:
- CLK_PER_BIT, 16: clk cycles per bit. Must be ≥4. M = CLK_PER_BIT/2, using integer division.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_serial_line  in  1  raw asynchronous serial input; idle = 1.
- rx_ready  out  1  one-cycle pulse; rx_data is valid with it.
- rx_data  out  8  last correctly framed byte; held until the next good byte.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled as 0.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values (async assert; deassert synchronised by design):
  - state = IDLE, cnt = 0, bit_idx = 0, shift = 0, armed = 0.
  - sync1 = sync2 = 1.
  - rx_data = 0x00, rx_ready = 0, frame_err = 0, busy = 0.
- Synchroniser: sync1 <= rx_serial_line; sync2 <= sync1. All decisions use sync2 only.
- armed: set when sync2 == 1 while in IDLE. It prevents starting a frame on a line that is already low at reset release (mid-frame reset or break condition).
- Bit windows: cnt counts 0..CLK_PER_BIT-1 within each bit window.
  - Majority votes sync2 at cnt = M-1, M, M+1 (2-of-3).
  - At cnt = CLK_PER_BIT-1, cnt returns to 0 and the next window begins.
- States:
  - IDLE: if armed and sync2 == 0 → START, cnt = 0.
  - START: at cnt = M+1, if vote == 1 → IDLE (glitch rejected, no pulse); else continue. At window end → DATA, bit_idx = 0.
  - DATA: at cnt = M+1, shift <= {vote, shift[7:1]} (LSB first). At window end: if bit_idx == 7 → STOP, else bit_idx + 1.
  - STOP: at cnt = M+1:
    - vote == 1: rx_data <= shift, rx_ready = 1 for one cycle, go to IDLE. Returning at M+1, not at window end, so a back-to-back start bit is not missed.
    - vote == 0: frame_err = 1 for one cycle, rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: remain until sync2 == 1, then IDLE. A held-low break yields exactly one frame_err and no further frames.
- Latency: let t0 be the first clk edge that samples rx_serial_line = 0 into sync1. rx_ready is high in the cycle after edge t0 + 9*CLK_PER_BIT + M + 4 (edge t0+156 for the default).
- rx_ready and frame_err are never high in the same cycle, and are never high for 2 consecutive cycles.
- Reset mid-frame: the partial byte is discarded with no pulse. The receiver does not start a frame until the line has been seen high.
- Tolerates ±4% baud mismatch at CLK_PER_BIT = 16 with correct data.

Test Plan:
1. Reset, line idle; send 0xA5 at exactly 16 clk/bit → one rx_ready pulse at t0+156, rx_data = 0xA5, frame_err never asserted, busy low afterwards.
2. Back-to-back 0x00 then 0xFF with no idle gap between the stop bit and the next start bit → two rx_ready pulses, rx_data 0x00 then 0xFF.
3. 3-cycle low glitch on idle line → busy rises then falls by cnt = M+1; no rx_ready, no frame_err, rx_data unchanged.
4. Send 0x3C with a 1-cycle inverted glitch aligned to cnt = M of bit 2 → majority corrects; rx_data = 0x3C.
5. Send 0x55 with stop bit driven 0, then hold the line low for 40 bit times → exactly one frame_err pulse, rx_data keeps its previous value, busy high until the line returns high; a subsequent 0x12 is received correctly.
6. Assert rst during bit 4 of a frame and release while the line is low → no pulse from the residue of that frame; the next full frame 0x81 is received correctly. Repeat at 15 and 17 clk/bit → 0x81 received in both cases.

Source files
------------

// File: rtl/uart_rx_sync_if.sv
// Serial receive bundle: raw line in, framed byte and status pulses out.
// The receiver takes the slave side; the line source / consumer takes master.
interface uart_rx_sync_if;
    logic       rx_serial_line;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx_serial_line,
        input  rx_ready,
        input  rx_data,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx_serial_line,
        output rx_ready,
        output rx_data,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// 8N1 UART receiver with 2-flop synchroniser, mid-bit 2-of-3 voting,
// false-start rejection and stop-bit framing check.
module uart_rx_sync #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_sync_if.slave bus
);
    localparam int M  = CLK_PER_BIT / 2;
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_V0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(M);
    localparam logic [CW-1:0] CNT_V2   = CW'(M + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          armed;
    logic          sync1;
    logic          sync2;
    logic [1:0]    sync_fill;
    logic          vs0;
    logic          vs1;
    logic          vote;
    logic [7:0]    rx_data_q;
    logic          rx_ready_q;
    logic          frame_err_q;

    assign vote = (vs0 & vs1) | (vs0 & sync2) | (vs1 & sync2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            armed       <= 1'b0;
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            sync_fill   <= '0;
            vs0         <= 1'b1;
            vs1         <= 1'b1;
            rx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1       <= bus.rx_serial_line;
            sync2       <= sync1;
            // sync2 only carries a genuine line sample two edges after reset release
            sync_fill   <= {sync_fill[0], 1'b1};
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (state != S_IDLE) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                if (cnt == CNT_V0) vs0 <= sync2;
                if (cnt == CNT_V1) vs1 <= sync2;
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (sync2 && sync_fill[1]) armed <= 1'b1;
                    if (armed && !sync2) state <= S_START;
                end
                S_START: begin
                    if (cnt == CNT_V2 && vote) begin
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_V2) shift <= {vote, shift[7:1]};
                    if (cnt == CNT_LAST) begin
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is caught
                    if (cnt == CNT_V2) begin
                        if (vote) begin
                            rx_data_q  <= shift;
                            rx_ready_q <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (sync2) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_sync.sv
// Scoreboard bench for uart_rx_sync: three instances (15/16/17 clk per bit),
// stimulus pushes expected pulses, negedge monitors pop and compare.
module tb_uart_rx_sync;
    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q16[$];
    exp_t q15[$];
    exp_t q17[$];
    bit   prev16 = 1'b0;
    bit   prev15 = 1'b0;
    bit   prev17 = 1'b0;

    uart_rx_sync_if if16 ();
    uart_rx_sync_if if15 ();
    uart_rx_sync_if if17 ();

    uart_rx_sync #(.CLK_PER_BIT(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    uart_rx_sync #(.CLK_PER_BIT(15)) dut15 (.clk(clk), .rst(rst), .bus(if15.slave));
    uart_rx_sync #(.CLK_PER_BIT(17)) dut17 (.clk(clk), .rst(rst), .bus(if17.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input int act, input int expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int which, input logic v);
        case (which)
            0:       if16.rx_serial_line = v;
            1:       if15.rx_serial_line = v;
            default: if17.rx_serial_line = v;
        endcase
    endtask

    task automatic push(input int which, input exp_t e);
        case (which)
            0:       q16.push_back(e);
            1:       q15.push_back(e);
            default: q17.push_back(e);
        endcase
    endtask

    // One 10-bit frame; optional single-cycle inversion at the middle sample
    // of frame bit glitch_idx. Expected pulse is queued before the frame starts.
    task automatic send_frame(input int which, input int cpb, input logic [7:0] d,
                              input bit stop_v, input logic [7:0] held,
                              input int glitch_idx, input bit chk_lat);
        exp_t       e;
        logic [9:0] bits;
        int         off;
        bits   = {stop_v, d, 1'b0};
        off    = cpb / 2 + 1;
        e.err  = !stop_v;
        e.data = stop_v ? d : held;
        e.cyc  = chk_lat ? cyc + 1 + 9 * cpb + cpb / 2 + 4 : 0;
        push(which, e);
        for (int i = 0; i < 10; i++) begin
            drive(which, bits[i]);
            if (i == glitch_idx) begin
                step(off);
                drive(which, !bits[i]);
                step(1);
                drive(which, bits[i]);
                step(cpb - off - 1);
            end else begin
                step(cpb);
            end
        end
    endtask

    task automatic mon(input int which, input logic rdy, input logic ferr,
                       input logic [7:0] d, input bit prev);
        exp_t e;
        bit   have;
        if (!(rdy || ferr)) return;
        chk("pulse_exclusive", !(rdy && ferr), {rdy, ferr}, 0);
        chk("pulse_single_cycle", !prev, prev, 0);
        have = 1'b0;
        case (which)
            0:       if (q16.size() > 0) begin e = q16.pop_front(); have = 1'b1; end
            1:       if (q15.size() > 0) begin e = q15.pop_front(); have = 1'b1; end
            default: if (q17.size() > 0) begin e = q17.pop_front(); have = 1'b1; end
        endcase
        chk("pulse_expected", have, which, 0);
        if (have) begin
            chk("pulse_kind_frame_err", ferr == e.err, ferr, e.err);
            chk("rx_data", d == e.data, d, e.data);
            if (e.cyc != 0) chk("rx_ready_latency", cyc == e.cyc, cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, if16.rx_ready, if16.frame_err, if16.rx_data, prev16);
            mon(1, if15.rx_ready, if15.frame_err, if15.rx_data, prev15);
            mon(2, if17.rx_ready, if17.frame_err, if17.rx_data, prev17);
        end
        prev16 = !rst && (if16.rx_ready || if16.frame_err);
        prev15 = !rst && (if15.rx_ready || if15.frame_err);
        prev17 = !rst && (if17.rx_ready || if17.frame_err);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "bench timeout");
    end

    initial begin
        if16.rx_serial_line = 1'b1;
        if15.rx_serial_line = 1'b1;
        if17.rx_serial_line = 1'b1;
        step(4);
        chk("reset_rx_data",   if16.rx_data == 8'h00, if16.rx_data, 8'h00);
        chk("reset_rx_ready",  if16.rx_ready == 1'b0, if16.rx_ready, 0);
        chk("reset_frame_err", if16.frame_err == 1'b0, if16.frame_err, 0);
        chk("reset_busy",      if16.busy == 1'b0, if16.busy, 0);
        rst = 1'b0;
        step(10);

        // 1: single byte, latency checked
        send_frame(0, 16, 8'hA5, 1'b1, 8'h00, -1, 1'b1);
        step(4);
        chk("busy_after_a5", if16.busy == 1'b0, if16.busy, 0);

        // 2: back-to-back, no idle gap
        send_frame(0, 16, 8'h00, 1'b1, 8'h00, -1, 1'b0);
        send_frame(0, 16, 8'hFF, 1'b1, 8'h00, -1, 1'b0);
        step(8);

        // 3: short low glitch on idle line
        drive(0, 1'b0);
        step(3);
        drive(0, 1'b1);
        chk("glitch_busy_rises", if16.busy == 1'b1, if16.busy, 1);
        step(12);
        chk("glitch_busy_falls", if16.busy == 1'b0, if16.busy, 0);
        step(20);
        chk("glitch_rx_data_held", if16.rx_data == 8'hFF, if16.rx_data, 8'hFF);

        // 4: mid-bit glitch on data bit 2 corrected by vote
        send_frame(0, 16, 8'h3C, 1'b1, 8'h00, 3, 1'b0);
        step(8);

        // 5: bad stop bit then a long break
        send_frame(0, 16, 8'h55, 1'b0, 8'h3C, -1, 1'b0);
        step(40 * 16);
        chk("break_busy_high", if16.busy == 1'b1, if16.busy, 1);
        chk("break_rx_data_held", if16.rx_data == 8'h3C, if16.rx_data, 8'h3C);
        drive(0, 1'b1);
        step(4);
        chk("break_busy_low", if16.busy == 1'b0, if16.busy, 0);
        step(16);
        send_frame(0, 16, 8'h12, 1'b1, 8'h00, -1, 1'b0);
        step(8);

        // 6: reset in bit 4 of a frame, released with line low
        drive(0, 1'b0);
        drive(1, 1'b0);
        drive(2, 1'b0);
        step(88);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(20);
        chk("rst_rx_data_16", if16.rx_data == 8'h00, if16.rx_data, 8'h00);
        chk("rst_busy_16",    if16.busy == 1'b0, if16.busy, 0);
        chk("rst_busy_15",    if15.busy == 1'b0, if15.busy, 0);
        chk("rst_busy_17",    if17.busy == 1'b0, if17.busy, 0);
        drive(0, 1'b1);
        drive(1, 1'b1);
        drive(2, 1'b1);
        step(40);
        fork
            send_frame(0, 16, 8'h81, 1'b1, 8'h00, -1, 1'b0);
            send_frame(1, 15, 8'h81, 1'b1, 8'h00, -1, 1'b0);
            send_frame(2, 17, 8'h81, 1'b1, 8'h00, -1, 1'b0);
        join
        step(40);

        chk("pending_16", q16.size() == 0, q16.size(), 0);
        chk("pending_15", q15.size() == 0, q15.size(), 0);
        chk("pending_17", q17.size() == 0, q17.size(), 0);
        chk("final_rx_data_15", if15.rx_data == 8'h81, if15.rx_data, 8'h81);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
